awm_tub_model: RTL and testbench

//  Plant-side responder for the washing-machine controller's valve interface: consumes input_valve/output_drain

---
 rtl/awm_tub_model.sv | 275 +++++++++++++++++++++++++++
 tb/tb_awm_tub_model.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/awm_tub_model.sv
// awm_tub_model: plant-side model of the washing-machine tub.
// Consumes the controller's input_valve / output_drain commands and tracks
// the water level, reporting level, empty/full, lid-lock, valve-conflict,
// sticky overflow / drain-timeout faults and a coarse tub state.
// Optional feature: define TUB_LEAK_EN to add the leak port and leak logic.
// Without it, the level changes only through the valves.
module awm_tub_model #(
  parameter int LEVEL_W       = 4,
  parameter int MAX_LEVEL     = 12,
  parameter int FILL_RATE     = 2,
  parameter int DRAIN_RATE    = 2,
  parameter int LOCK_LEVEL    = 3,
  parameter int DRAIN_TIMEOUT = 40,
  parameter int LEAK_RATE     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               input_valve,
  input  logic               output_drain,
  input  logic               fault_clr,
`ifdef TUB_LEAK_EN
  input  logic               leak,
`endif
  output logic [LEVEL_W-1:0] level,
  output logic               tub_empty,
  output logic               tub_full,
  output logic               lid_lock,
  output logic               valve_conflict,
  output logic               overflow,
  output logic               drain_fault,
  output logic [2:0]         tub_state
);

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_FILLING  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_DRAINING = 3'd3,
    ST_FAULT    = 3'd4
  } tub_state_e;

  localparam int FILL_PW  = $clog2(FILL_RATE + 1);
  localparam int DRAIN_PW = $clog2(DRAIN_RATE + 1);
  localparam int TMR_W    = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [FILL_PW-1:0]  FILL_LAST  = FILL_PW'(FILL_RATE - 1);
  localparam logic [DRAIN_PW-1:0] DRAIN_LAST = DRAIN_PW'(DRAIN_RATE - 1);
  localparam logic [TMR_W-1:0]    TMR_MAX    = TMR_W'(DRAIN_TIMEOUT);
  localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [LEVEL_W-1:0]  LVL_MAX    = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0]  LVL_LOCK   = LEVEL_W'(LOCK_LEVEL);

`ifdef TUB_LEAK_EN
  localparam int LEAK_PW = $clog2(LEAK_RATE + 1);
  localparam logic [LEAK_PW-1:0] LEAK_LAST = LEAK_PW'(LEAK_RATE - 1);
`endif

  // State decode: faults dominate, then the active valve, then the level.
  function automatic tub_state_e f_next_state(input logic fault_any,
                                              input logic sole_fill,
                                              input logic sole_drain,
                                              input logic level_nz);
    tub_state_e ns;
    if (fault_any) begin
      ns = ST_FAULT;
    end else if (sole_fill) begin
      ns = ST_FILLING;
    end else if (sole_drain && level_nz) begin
      ns = ST_DRAINING;
    end else if (!level_nz) begin
      ns = ST_EMPTY;
    end else begin
      ns = ST_HOLD;
    end
    return ns;
  endfunction

  // Registered state
  logic [LEVEL_W-1:0]  level_r;
  logic [FILL_PW-1:0]  fill_pre_r;
  logic [DRAIN_PW-1:0] drain_pre_r;
  logic [TMR_W-1:0]    drain_tmr_r;
  logic                conflict_r;
  logic                overflow_r;
  logic                drain_fault_r;
  tub_state_e          state_r;

  // Next-state values
  logic [LEVEL_W-1:0]  level_s;
  logic [FILL_PW-1:0]  fill_pre_s;
  logic [DRAIN_PW-1:0] drain_pre_s;
  logic [TMR_W-1:0]    drain_tmr_s;
  logic                overflow_s;
  logic                drain_fault_s;
  tub_state_e          state_s;

  // Decoded conditions
  logic sole_fill_s;
  logic sole_drain_s;
  logic both_s;
  logic level_nz_s;
  logic at_max_s;
  logic fill_wrap_s;
  logic drain_wrap_s;
  logic fill_inc_s;
  logic drain_dec_s;
  logic leak_dec_s;
  logic overflow_set_s;
  logic drain_set_s;

`ifdef TUB_LEAK_EN
  logic [LEAK_PW-1:0] leak_pre_r;
  logic [LEAK_PW-1:0] leak_pre_s;
  logic               leak_wrap_s;
`endif

  // Valve decode and the fill/drain prescalers; both prescalers freeze during a conflict.
  always_comb begin
    sole_fill_s  = input_valve & ~output_drain;
    sole_drain_s = output_drain & ~input_valve;
    both_s       = input_valve & output_drain;
    level_nz_s   = (level_r != LEVEL_W'(0));
    at_max_s     = (level_r == LVL_MAX);
    fill_wrap_s  = 1'b0;
    drain_wrap_s = 1'b0;
    fill_pre_s   = fill_pre_r;
    drain_pre_s  = drain_pre_r;

    if (both_s) begin
      fill_pre_s = fill_pre_r;
    end else if (sole_fill_s) begin
      if (fill_pre_r == FILL_LAST) begin
        fill_pre_s  = FILL_PW'(0);
        fill_wrap_s = 1'b1;
      end else begin
        fill_pre_s = fill_pre_r + FILL_PW'(1);
      end
    end else begin
      fill_pre_s = FILL_PW'(0);
    end

    if (both_s) begin
      drain_pre_s = drain_pre_r;
    end else if (sole_drain_s) begin
      if (drain_pre_r == DRAIN_LAST) begin
        drain_pre_s  = DRAIN_PW'(0);
        drain_wrap_s = 1'b1;
      end else begin
        drain_pre_s = drain_pre_r + DRAIN_PW'(1);
      end
    end else begin
      drain_pre_s = DRAIN_PW'(0);
    end
  end

`ifdef TUB_LEAK_EN
  // Leak prescaler: runs only while leak is injected, independent of the valves.
  always_comb begin
    leak_wrap_s = 1'b0;
    leak_pre_s  = leak_pre_r;
    if (leak) begin
      if (leak_pre_r == LEAK_LAST) begin
        leak_pre_s  = LEAK_PW'(0);
        leak_wrap_s = 1'b1;
      end else begin
        leak_pre_s = leak_pre_r + LEAK_PW'(1);
      end
    end else begin
      leak_pre_s = LEAK_PW'(0);
    end
  end
`endif

  // Level update, saturation, drain timer, sticky faults and next tub state.
  always_comb begin
`ifdef TUB_LEAK_EN
    leak_dec_s = leak_wrap_s & level_nz_s;
`else
    leak_dec_s = 1'b0;
`endif
    // Fill increments are suppressed while faulted and at the full mark.
    fill_inc_s     = fill_wrap_s & ~at_max_s & (state_r != ST_FAULT);
    drain_dec_s    = drain_wrap_s & level_nz_s;
    overflow_set_s = fill_wrap_s & at_max_s;
    level_s        = level_r;

    if (fill_inc_s && leak_dec_s) begin
      level_s = level_r;
    end else if (fill_inc_s) begin
      level_s = level_r + LEVEL_W'(1);
    end else if (drain_dec_s && leak_dec_s) begin
      if (level_r > LEVEL_W'(1)) begin
        level_s = level_r - LEVEL_W'(2);
      end else begin
        level_s = LEVEL_W'(0);
      end
    end else if (drain_dec_s || leak_dec_s) begin
      level_s = level_r - LEVEL_W'(1);
    end else begin
      level_s = level_r;
    end

    // The timer watches the raw drain command so a stuck conflict also times out.
    drain_set_s = output_drain & level_nz_s & (drain_tmr_r == TMR_LAST);
    drain_tmr_s = drain_tmr_r;
    if (fault_clr) begin
      drain_tmr_s = TMR_W'(0);
    end else if (output_drain && level_nz_s) begin
      if (drain_tmr_r == TMR_MAX) begin
        drain_tmr_s = drain_tmr_r;
      end else begin
        drain_tmr_s = drain_tmr_r + TMR_W'(1);
      end
    end else begin
      drain_tmr_s = TMR_W'(0);
    end

    // A fault raised in the same cycle as fault_clr survives the clear.
    if (fault_clr) begin
      overflow_s    = overflow_set_s;
      drain_fault_s = drain_set_s;
    end else begin
      overflow_s    = overflow_r | overflow_set_s;
      drain_fault_s = drain_fault_r | drain_set_s;
    end

    state_s = f_next_state(overflow_s | drain_fault_s, sole_fill_s,
                           sole_drain_s, level_nz_s);
  end

  // State registers with asynchronous reset to the empty, fault-free tub.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r       <= LEVEL_W'(0);
      fill_pre_r    <= FILL_PW'(0);
      drain_pre_r   <= DRAIN_PW'(0);
      drain_tmr_r   <= TMR_W'(0);
      conflict_r    <= 1'b0;
      overflow_r    <= 1'b0;
      drain_fault_r <= 1'b0;
      state_r       <= ST_EMPTY;
    end else begin
      level_r       <= level_s;
      fill_pre_r    <= fill_pre_s;
      drain_pre_r   <= drain_pre_s;
      drain_tmr_r   <= drain_tmr_s;
      conflict_r    <= both_s;
      overflow_r    <= overflow_s;
      drain_fault_r <= drain_fault_s;
      state_r       <= state_s;
    end
  end

`ifdef TUB_LEAK_EN
  // Leak prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leak_pre_r <= LEAK_PW'(0);
    end else begin
      leak_pre_r <= leak_pre_s;
    end
  end
`endif

  // Level flags decode straight from the level register, adding no latency.
  assign level          = level_r;
  assign tub_empty      = (level_r == LEVEL_W'(0));
  assign tub_full       = (level_r == LVL_MAX);
  assign lid_lock       = (level_r >= LVL_LOCK);
  assign valve_conflict = conflict_r;
  assign overflow       = overflow_r;
  assign drain_fault    = drain_fault_r;
  assign tub_state      = state_r;

endmodule

// File: tb/tb_awm_tub_model.sv
// tb_awm_tub_model: table-driven directed bench for awm_tub_model with default
// parameters, plus hand-written sequences for asynchronous reset mid-operation
// and (with TUB_LEAK_EN) the leak feature.
module tb_awm_tub_model;

  localparam int S_EMPTY = 0;
  localparam int S_FILL  = 1;
  localparam int S_HOLD  = 2;
  localparam int S_DRAIN = 3;
  localparam int S_FAULT = 4;
  localparam int NV      = 31;

  logic       clk;
  logic       reset;
  logic       input_valve;
  logic       output_drain;
  logic       fault_clr;
  logic       leak;
  logic [3:0] level;
  logic       tub_empty;
  logic       tub_full;
  logic       lid_lock;
  logic       valve_conflict;
  logic       overflow;
  logic       drain_fault;
  logic [2:0] tub_state;

  int n_checks;
  int n_fail;

  typedef struct {
    logic iv;
    logic od;
    logic fc;
    int   n;
    int   lvl;
    logic cfl;
    logic ovf;
    logic dfl;
    int   st;
  } vec_t;

  vec_t vecs[NV];

  awm_tub_model dut (
    .clk            (clk),
    .reset          (reset),
    .input_valve    (input_valve),
    .output_drain   (output_drain),
    .fault_clr      (fault_clr),
`ifdef TUB_LEAK_EN
    .leak           (leak),
`endif
    .level          (level),
    .tub_empty      (tub_empty),
    .tub_full       (tub_full),
    .lid_lock       (lid_lock),
    .valve_conflict (valve_conflict),
    .overflow       (overflow),
    .drain_fault    (drain_fault),
    .tub_state      (tub_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic od, input logic fc,
                              input int n, input int lvl, input logic cfl,
                              input logic ovf, input logic dfl, input int st);
    vec_t v;
    v.iv = iv; v.od = od; v.fc = fc; v.n = n; v.lvl = lvl;
    v.cfl = cfl; v.ovf = ovf; v.dfl = dfl; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Level flags follow from the expected level with MAX_LEVEL=12, LOCK_LEVEL=3.
  task automatic chk_all(input string tag, input int lvl, input logic cfl,
                         input logic ovf, input logic dfl, input int st);
    chk({tag, " level"},    int'(level),          lvl);
    chk({tag, " empty"},    int'(tub_empty),      (lvl == 0) ? 1 : 0);
    chk({tag, " full"},     int'(tub_full),       (lvl == 12) ? 1 : 0);
    chk({tag, " lid_lock"}, int'(lid_lock),       (lvl >= 3) ? 1 : 0);
    chk({tag, " conflict"}, int'(valve_conflict), int'(cfl));
    chk({tag, " overflow"}, int'(overflow),       int'(ovf));
    chk({tag, " dfault"},   int'(drain_fault),    int'(dfl));
    chk({tag, " state"},    int'(tub_state),      st);
  endtask

  task automatic drive(input logic iv, input logic od, input logic fc, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      input_valve  = iv;
      output_drain = od;
      fault_clr    = fc;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    clk          = 1'b0;
    reset        = 1'b1;
    input_valve  = 1'b0;
    output_drain = 1'b0;
    fault_clr    = 1'b0;
    leak         = 1'b0;

    //          iv    od    fc    n   lvl cfl   ovf   dfl   state
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1,  1, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 2,  2, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 2,  3, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 2,  4, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1,  4, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 5,  4, 1'b1, 1'b0, 1'b0, S_HOLD);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 5,  5, 1'b1, 1'b0, 1'b0, S_HOLD);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, S_HOLD);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, S_DRAIN);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1,  4, 1'b0, 1'b0, 1'b0, S_DRAIN);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 7,  1, 1'b0, 1'b0, 1'b0, S_DRAIN);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, S_DRAIN);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, S_EMPTY);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 2,  0, 1'b0, 1'b0, 1'b0, S_EMPTY);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 24, 12, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 1,  12, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 1,  12, 1'b0, 1'b1, 1'b0, S_FAULT);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 4,  12, 1'b0, 1'b1, 1'b0, S_FAULT);
    vecs[20] = mk(1'b0, 1'b0, 1'b1, 1,  12, 1'b0, 1'b0, 1'b0, S_HOLD);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 1,  12, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[22] = mk(1'b1, 1'b0, 1'b1, 1,  12, 1'b0, 1'b1, 1'b0, S_FAULT);
    vecs[23] = mk(1'b0, 1'b0, 1'b1, 1,  12, 1'b0, 1'b0, 1'b0, S_HOLD);
    vecs[24] = mk(1'b1, 1'b1, 1'b0, 39, 12, 1'b1, 1'b0, 1'b0, S_HOLD);
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 1,  12, 1'b1, 1'b0, 1'b1, S_FAULT);
    vecs[26] = mk(1'b0, 1'b1, 1'b0, 2,  11, 1'b0, 1'b0, 1'b1, S_FAULT);
    vecs[27] = mk(1'b1, 1'b0, 1'b0, 2,  11, 1'b0, 1'b0, 1'b1, S_FAULT);
    vecs[28] = mk(1'b0, 1'b0, 1'b1, 1,  11, 1'b0, 1'b0, 1'b0, S_HOLD);
    vecs[29] = mk(1'b1, 1'b0, 1'b0, 1,  11, 1'b0, 1'b0, 1'b0, S_FILL);
    vecs[30] = mk(1'b1, 1'b0, 1'b0, 1,  12, 1'b0, 1'b0, 1'b0, S_FILL);

    // Reset state, observed while reset is still held.
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, S_EMPTY);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].od, vecs[i].fc, vecs[i].n);
      chk_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].cfl,
              vecs[i].ovf, vecs[i].dfl, vecs[i].st);
    end

    // Build up overflow, a pending fill prescaler count and a conflict, then reset mid-cycle.
    drive(1'b1, 1'b0, 1'b0, 2);
    chk_all("pre_rst_ovf", 12, 1'b0, 1'b1, 1'b0, S_FAULT);
    drive(1'b1, 1'b0, 1'b0, 1);
    drive(1'b1, 1'b1, 1'b0, 1);
    chk_all("pre_rst_cfl", 12, 1'b1, 1'b1, 1'b0, S_FAULT);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0, S_EMPTY);
    @(negedge clk);
    reset        = 1'b0;
    input_valve  = 1'b1;
    output_drain = 1'b0;
    fault_clr    = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_1", 0, 1'b0, 1'b0, 1'b0, S_FILL);
    @(posedge clk);
    #1;
    chk_all("post_rst_2", 1, 1'b0, 1'b0, 1'b0, S_FILL);

`ifdef TUB_LEAK_EN
    // Raise level to 5, then leak for 16 cycles with the valves closed.
    drive(1'b1, 1'b0, 1'b0, 8);
    chk_all("leak_pre", 5, 1'b0, 1'b0, 1'b0, S_FILL);
    @(negedge clk);
    input_valve = 1'b0;
    leak        = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16);
    leak = 1'b0;
    chk_all("leak_16", 3, 1'b0, 1'b0, 1'b0, S_HOLD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
